// File: rtl/sensor_debounce.sv
// Three-channel debounce filter for the line sensors.
// Each channel flips its filtered bit only after STABLE_CYCLES consecutive differing samples.
module sensor_debounce #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 16,
  parameter logic [2:0]  RESET_VAL     = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_l_in,
  input  logic       sensor_m_in,
  input  logic       sensor_r_in,
  input  logic       glitch_clr,
  output logic       sensor_l_out,
  output logic       sensor_m_out,
  output logic       sensor_r_out,
  output logic       sensor_changed,
  output logic [7:0] glitch_cnt
);

  // The threshold is compared one bit wider so cnt+1 never wraps before the compare.
  localparam logic [CNT_W:0]   LIMIT    = (CNT_W+1)'(STABLE_CYCLES);
  localparam logic [CNT_W:0]   ONE_WIDE = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [2:0]       raw;
  logic [2:0]       filt_q, filt_d;
  logic [2:0]       abort;
  logic [2:0]       flip;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic             changed_q, changed_d;
  logic [7:0]       glitch_q, glitch_d;
  logic [1:0]       abort_sum;
  logic [8:0]       glitch_sum;

  // Bit 2 = left, bit 1 = middle, bit 0 = right.
  assign raw = {sensor_l_in, sensor_m_in, sensor_r_in};

  always_comb begin
    filt_d = filt_q;
    abort  = '0;
    flip   = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (raw[i] == filt_q[i]) begin
        if (cnt_q[i] != '0) begin
          abort[i] = 1'b1;
          cnt_d[i] = '0;
        end
      end else if (({1'b0, cnt_q[i]} + ONE_WIDE) == LIMIT) begin
        filt_d[i] = raw[i];
        cnt_d[i]  = '0;
        flip[i]   = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + ONE_CNT;
      end
    end
  end

  // Up to three aborts may land on one edge; the sum saturates rather than wraps.
  always_comb begin
    abort_sum  = 2'(abort[0]) + 2'(abort[1]) + 2'(abort[2]);
    glitch_sum = {1'b0, glitch_q} + {7'b0, abort_sum};
    changed_d  = |flip;
    glitch_d   = glitch_q;
    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_sum > 9'd255) begin
      glitch_d = 8'hFF;
    end else begin
      glitch_d = glitch_sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q    <= RESET_VAL;
      changed_q <= 1'b0;
      glitch_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      filt_q    <= filt_d;
      changed_q <= changed_d;
      glitch_q  <= glitch_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sensor_l_out   = filt_q[2];
  assign sensor_m_out   = filt_q[1];
  assign sensor_r_out   = filt_q[0];
  assign sensor_changed = changed_q;
  assign glitch_cnt     = glitch_q;

endmodule

// File: tb/tb_sensor_debounce.sv
// Self-checking bench for sensor_debounce with STABLE_CYCLES=4.
// Directed scenarios followed by a random phase, all compared against a run-length reference model.
module tb_sensor_debounce;

  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       l_in, m_in, r_in, clr_in;
  logic       l_out, m_out, r_out, changed;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: index 0 = left, 1 = middle, 2 = right.
  int run_len [3];
  bit exp_filt [3];
  bit exp_changed;
  int exp_glitch;

  sensor_debounce #(
    .STABLE_CYCLES(SC),
    .CNT_W        (16),
    .RESET_VAL    (3'b000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sensor_l_in   (l_in),
    .sensor_m_in   (m_in),
    .sensor_r_in   (r_in),
    .glitch_clr    (clr_in),
    .sensor_l_out  (l_out),
    .sensor_m_out  (m_out),
    .sensor_r_out  (r_out),
    .sensor_changed(changed),
    .glitch_cnt    (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      run_len[i]  = 0;
      exp_filt[i] = 1'b0;
    end
    exp_changed = 1'b0;
    exp_glitch  = 0;
  endtask

  // One clock edge of the specification's rules, using the inputs sampled at that edge.
  task automatic model_edge();
    bit raw [3];
    int aborts = 0;
    bit any    = 1'b0;
    raw[0] = l_in;
    raw[1] = m_in;
    raw[2] = r_in;
    for (int i = 0; i < 3; i++) begin
      if (raw[i] == exp_filt[i]) begin
        if (run_len[i] > 0) aborts++;
        run_len[i] = 0;
      end else begin
        run_len[i]++;
        if (run_len[i] == SC) begin
          exp_filt[i] = raw[i];
          run_len[i]  = 0;
          any         = 1'b1;
        end
      end
    end
    exp_changed = any;
    if (clr_in) exp_glitch = 0;
    else        exp_glitch = (exp_glitch + aborts > 255) ? 255 : exp_glitch + aborts;
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "_l"},      8'(l_out),   8'(exp_filt[0]));
    check_output({tag, "_m"},      8'(m_out),   8'(exp_filt[1]));
    check_output({tag, "_r"},      8'(r_out),   8'(exp_filt[2]));
    check_output({tag, "_chg"},    8'(changed), 8'(exp_changed));
    check_output({tag, "_glitch"}, glitch_cnt,  8'(exp_glitch));
  endtask

  task automatic apply_stimulus(input logic l, input logic m, input logic r, input logic clr,
                                input string tag);
    l_in   = l;
    m_in   = m;
    r_in   = r;
    clr_in = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n  = 1'b0;
    l_in   = 1'b0;
    m_in   = 1'b0;
    r_in   = 1'b0;
    clr_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Middle rises and holds: output follows on the 4th sampling edge.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t1_wait");
      check_output("t1_m_low", 8'(m_out), 8'd0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t1_flip");
    check_output("t1_m_high", 8'(m_out), 8'd1);
    check_output("t1_pulse", 8'(changed), 8'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t1_after");
    check_output("t1_pulse_end", 8'(changed), 8'd0);

    // Left pulses for three edges then drops: one glitch, no output change.
    repeat (3) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "t2_pend");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t2_abort");
    check_output("t2_l_low", 8'(l_out), 8'd0);
    check_output("t2_glitch", glitch_cnt, 8'd1);
    check_output("t2_no_pulse", 8'(changed), 8'd0);

    // All three channels glitch together, then many bursts to saturate.
    repeat (2) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "t3_pend");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t3_abort");
    check_output("t3_jump3", glitch_cnt, 8'd4);
    for (int b = 0; b < 90; b++) begin
      repeat (2) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "t3_burst_pend");
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t3_burst_abort");
    end
    check_output("t3_saturate", glitch_cnt, 8'd255);

    // Clear on the same edge as an abort wins.
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, "t4_pend");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, "t4_clr");
    check_output("t4_cleared", glitch_cnt, 8'd0);

    // Left and right rise together: single shared change pulse.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, "t5_wait");
      check_output("t5_l_low", 8'(l_out), 8'd0);
      check_output("t5_r_low", 8'(r_out), 8'd0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, "t5_flip");
    check_output("t5_l_high", 8'(l_out), 8'd1);
    check_output("t5_r_high", 8'(r_out), 8'd1);
    check_output("t5_pulse", 8'(changed), 8'd1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, "t5_after");
    check_output("t5_pulse_end", 8'(changed), 8'd0);

    // Return all outputs to 0, then reset in the middle of a pending rise.
    repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, "t6_lower");
    check_output("t6_m_lowered", 8'(m_out), 8'd0);
    repeat (2) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t6_pend");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t6_restart");
      check_output("t6_m_low", 8'(m_out), 8'd0);
    end
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, "t6_flip");
    check_output("t6_m_high", 8'(m_out), 8'd1);

    // Random phase: inputs toggle occasionally so both aborts and completed flips occur.
    for (int n = 0; n < 1500; n++) begin
      logic nl, nm, nr, nc;
      nl = ($urandom_range(0, 4) == 0) ? ~l_in : l_in;
      nm = ($urandom_range(0, 4) == 0) ? ~m_in : m_in;
      nr = ($urandom_range(0, 4) == 0) ? ~r_in : r_in;
      nc = ($urandom_range(0, 49) == 0);
      apply_stimulus(nl, nm, nr, nc, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
